// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receive path: parity modes,
// receiver FSM encoding and the layout of a receive FIFO entry.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_e;

  // Flag offsets above the data field: entry = {brk, ferr, perr, data}.
  localparam int ENT_PERR_OFS = 0;
  localparam int ENT_FERR_OFS = 1;
  localparam int ENT_BRK_OFS  = 2;
  localparam int ENT_FLAG_W   = 3;

endpackage

// File: rtl/baud_gen.sv
// Free-running oversampling tick generator: one-cycle tick every dvsr+1 clocks.
module baud_gen #(
  parameter int DVSR_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  output logic              tick_o
);

  logic [DVSR_W-1:0] cnt_q, cnt_d;

  // Wrapping on >= keeps a shrinking divisor from stalling the counter.
  always_comb begin
    cnt_d = (cnt_q >= dvsr_i) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == dvsr_i);

endmodule

// File: rtl/fifo.sv
// First-word fall-through FIFO; head reads as zero while empty.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH-1:0] w_succ, r_succ;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  wr_en, rd_en;

  // A read frees the slot a simultaneous write needs, so full+read+write is legal.
  assign rd_en  = rd_i && !empty_q;
  assign wr_en  = wr_i && (!full_q || rd_i);
  assign w_succ = w_ptr_q + 1'b1;
  assign r_succ = r_ptr_q + 1'b1;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    empty_d = empty_q;
    full_d  = full_q;
    case ({wr_en, rd_en})
      2'b10: begin
        w_ptr_d = w_succ;
        empty_d = 1'b0;
        full_d  = (w_succ == r_ptr_q);
      end
      2'b01: begin
        r_ptr_d = r_succ;
        full_d  = 1'b0;
        empty_d = (r_succ == w_ptr_q);
      end
      2'b11: begin
        w_ptr_d = w_succ;
        r_ptr_d = r_succ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[w_ptr_q] <= w_data_i;
  end

  assign r_data_o = empty_q ? '0 : mem_q[r_ptr_q];
  assign empty_o  = empty_q;
  assign full_o   = full_q;

endmodule

// File: rtl/uart_rx_cfg_core.sv
// Receive engine: rx synchroniser, oversampled frame FSM, parity/framing/break
// evaluation, and a one-cycle frame_done strobe carrying the finished entry.
module uart_rx_cfg_core
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            s_tick_i,
  input  logic            rx_i,
  input  logic [1:0]      parity_mode_i,
  input  logic            stop2_i,
  output logic            frame_done_o,
  output logic [DBIT+2:0] entry_o,
  output rx_state_e       state_o
);

  localparam int S_W = $clog2(SB_TICK);
  localparam int N_W = $clog2(DBIT + 1);
  localparam logic [S_W-1:0] S_HALF = S_W'(SB_TICK / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

  rx_state_e       state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            pbit_q, pbit_d, ferr_q, ferr_d, stop2_q, stop2_d;
  logic [1:0]      pmode_q, pmode_d;
  logic            mid_tick, last_stop, par_en;
  logic            ferr_fin, par_x, perr, brk;

  assign mid_tick  = s_tick_i && (s_q == S_LAST);
  assign last_stop = (n_q == N_W'(stop2_q));
  assign par_en    = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      pbit_q    <= 1'b0;
      ferr_q    <= 1'b0;
      pmode_q   <= PAR_NONE;
      stop2_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      pbit_q    <= pbit_d;
      ferr_q    <= ferr_d;
      pmode_q   <= pmode_d;
      stop2_q   <= stop2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    pbit_d  = pbit_q;
    ferr_d  = ferr_q;
    pmode_d = pmode_q;
    stop2_d = stop2_q;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          // Frame format is frozen here so mid-frame reconfiguration is harmless.
          state_d = START;
          s_d     = '0;
          pbit_d  = 1'b0;
          ferr_d  = 1'b0;
          pmode_d = parity_mode_i;
          stop2_d = stop2_i;
        end
      end
      START: begin
        if (s_tick_i) begin
          if (s_q == S_HALF) begin
            s_d     = '0;
            n_d     = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick_i) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              n_d     = '0;
              state_d = par_en ? PARITY : STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick_i) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            pbit_d  = rx_s_q;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick_i) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            if (!rx_s_q) ferr_d = 1'b1;
            if (last_stop) state_d = rx_s_q ? IDLE : BREAK_WAIT;
            else           n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      BREAK_WAIT: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The final stop sample is folded in combinationally so the entry is ready
  // on the same cycle frame_done is raised.
  always_comb begin
    frame_done_o = (state_q == STOP) && mid_tick && last_stop;
    ferr_fin     = ferr_q | ~rx_s_q;
    par_x        = (^b_q) ^ pbit_q;
    case (pmode_q)
      PAR_EVEN: perr = par_x;
      PAR_ODD:  perr = ~par_x;
      PAR_NONE: perr = 1'b0;
      default:  perr = 1'b0;
    endcase
    brk = (b_q == '0) && !pbit_q && ferr_fin;
    entry_o                      = '0;
    entry_o[DBIT-1:0]            = b_q;
    entry_o[DBIT + ENT_PERR_OFS] = perr;
    entry_o[DBIT + ENT_FERR_OFS] = ferr_fin;
    entry_o[DBIT + ENT_BRK_OFS]  = brk;
    state_o                      = state_q;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver top: baud tick, receive core, entry FIFO and the
// sticky overrun flag for frames dropped on a full FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int DVSR_W     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              rx,
  input  logic              rd_uart,
  input  logic              clr_ovr,
  output logic [DBIT-1:0]   r_data,
  output logic              r_perr,
  output logic              r_ferr,
  output logic              r_brk,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              rx_overrun,
  output logic              rx_busy
);

  localparam int EW = DBIT + ENT_FLAG_W;

  logic          s_tick, frame_done;
  logic [EW-1:0] entry, head;
  rx_state_e     rx_state;
  logic          ovr_q, ovr_d;

  baud_gen #(.DVSR_W(DVSR_W)) u_baud (
    .clk_i (clk),
    .rst_i (reset),
    .dvsr_i(dvsr),
    .tick_o(s_tick)
  );

  uart_rx_cfg_core #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_core (
    .clk_i        (clk),
    .rst_i        (reset),
    .s_tick_i     (s_tick),
    .rx_i         (rx),
    .parity_mode_i(parity_mode),
    .stop2_i      (stop2),
    .frame_done_o (frame_done),
    .entry_o      (entry),
    .state_o      (rx_state)
  );

  fifo #(.DATA_WIDTH(EW), .ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .wr_i    (frame_done),
    .rd_i    (rd_uart),
    .w_data_i(entry),
    .r_data_o(head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  // Set has priority so an overrun coinciding with clr_ovr is not lost.
  always_comb begin
    ovr_d = ovr_q;
    if (clr_ovr) ovr_d = 1'b0;
    if (frame_done && rx_full && !rd_uart) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  assign r_data     = head[DBIT-1:0];
  assign r_perr     = head[DBIT + ENT_PERR_OFS];
  assign r_ferr     = head[DBIT + ENT_FERR_OFS];
  assign r_brk      = head[DBIT + ENT_BRK_OFS];
  assign rx_overrun = ovr_q;
  assign rx_busy    = (rx_state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: serial frames are driven bit by bit and the
// expected FIFO entries {brk, ferr, perr, data} are queued and matched on read.
module tb_uart_rx_cfg;

  localparam int DBIT       = 8;
  localparam int SB_TICK    = 16;
  localparam int ADDR_WIDTH = 2;
  localparam int DVSR_W     = 11;
  localparam int W          = DBIT + 3;
  localparam int BIT_CLK    = 64;

  logic              clk = 1'b0;
  logic              reset, stop2, rx, rd_uart, clr_ovr;
  logic [DVSR_W-1:0] dvsr;
  logic [1:0]        parity_mode;
  logic [DBIT-1:0]   r_data;
  logic              r_perr, r_ferr, r_brk;
  logic              rx_empty, rx_full, rx_overrun, rx_busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .DBIT(DBIT), .SB_TICK(SB_TICK), .ADDR_WIDTH(ADDR_WIDTH), .DVSR_W(DVSR_W)
  ) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .parity_mode(parity_mode),
    .stop2(stop2), .rx(rx), .rd_uart(rd_uart), .clr_ovr(clr_ovr),
    .r_data(r_data), .r_perr(r_perr), .r_ferr(r_ferr), .r_brk(r_brk),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_overrun(rx_overrun),
    .rx_busy(rx_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    clks(BIT_CLK);
  endtask

  // Leaves rx at the last stop value so a low second stop can hold the line.
  task automatic send_frame(input logic [DBIT-1:0] d, input bit has_par,
                            input logic pbit, input bit two_stop, input logic stop_b);
    rx = 1'b1;
    clks(16);
    drive_bit(1'b0);
    for (int i = 0; i < DBIT; i++) drive_bit(d[i]);
    if (has_par) drive_bit(pbit);
    drive_bit(1'b1);
    if (two_stop) drive_bit(stop_b);
  endtask

  task automatic read_head(input string tag);
    int n;
    logic [W-1:0] exp;
    n = 0;
    while (rx_empty && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(rx_empty), 32'd0);
    if (!rx_empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_sb: observed=%0h expected=no entry", tag, {r_brk, r_ferr, r_perr, r_data});
      end else begin
        exp = exp_q.pop_front();
        chk(tag, 32'({r_brk, r_ferr, r_perr, r_data}), 32'(exp));
      end
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; dvsr = 11'd3; parity_mode = 2'b00; stop2 = 1'b0;
    rx = 1'b1; rd_uart = 1'b0; clr_ovr = 1'b0;
    clks(3);
    reset = 1'b0;
    clks(1);
    chk("rst_empty",   32'(rx_empty),   32'd1);
    chk("rst_full",    32'(rx_full),    32'd0);
    chk("rst_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_busy",    32'(rx_busy),    32'd0);
    chk("rst_head",    32'({r_brk, r_ferr, r_perr, r_data}), 32'd0);

    // 8N1 basic frame
    exp_q.push_back(11'h0A5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_nonempty", 32'(rx_empty), 32'd0);
    read_head("a5");
    chk("a5_drained", 32'(rx_empty), 32'd1);

    // Even then odd parity on the same wire pattern
    parity_mode = 2'b01;
    exp_q.push_back(11'h103);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
    read_head("par_even");
    parity_mode = 2'b10;
    exp_q.push_back(11'h003);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
    read_head("par_odd");

    // Two stop bits, second one low: framing error, then held in BREAK_WAIT
    parity_mode = 2'b00;
    stop2 = 1'b1;
    exp_q.push_back(11'h23C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    clks(16);
    chk("stop2_brkwait_busy", 32'(rx_busy), 32'd1);
    read_head("stop2_ferr");
    rx = 1'b1;
    clks(8);
    chk("stop2_released", 32'(rx_busy), 32'd0);
    stop2 = 1'b0;

    // Long break produces exactly one entry
    clks(16);
    rx = 1'b0;
    clks(20 * BIT_CLK);
    chk("break_busy", 32'(rx_busy), 32'd1);
    rx = 1'b1;
    clks(8);
    exp_q.push_back(11'h600);
    read_head("break");
    chk("break_single", 32'(rx_empty), 32'd1);
    exp_q.push_back(11'h055);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    read_head("after_break");

    // Fill the FIFO, then overrun with a fifth frame
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(11'(i * 8'h11));
      send_frame(8'(i * 8'h11), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("fill_full",    32'(rx_full),    32'd1);
    chk("fill_no_ovr",  32'(rx_overrun), 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_set",      32'(rx_overrun), 32'd1);
    chk("ovr_full",     32'(rx_full),    32'd1);
    for (int i = 1; i <= 4; i++) read_head("fill_read");
    chk("fill_drained", 32'(rx_empty),   32'd1);
    chk("ovr_sticky",   32'(rx_overrun), 32'd1);
    clr_ovr = 1'b1;
    clks(1);
    clr_ovr = 1'b0;
    chk("ovr_cleared",  32'(rx_overrun), 32'd0);

    // Glitch shorter than half a bit
    clks(16);
    rx = 1'b0;
    clks(8);
    chk("glitch_busy", 32'(rx_busy), 32'd1);
    rx = 1'b1;
    clks(BIT_CLK);
    chk("glitch_idle",  32'(rx_busy),  32'd0);
    chk("glitch_empty", 32'(rx_empty), 32'd1);

    // Reset in the middle of the data bits
    rx = 1'b0;
    clks(BIT_CLK);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    chk("midrst_busy", 32'(rx_busy), 32'd1);
    reset = 1'b1;
    clks(2);
    rx = 1'b1;
    reset = 1'b0;
    clks(2);
    chk("midrst_idle",  32'(rx_busy),  32'd0);
    chk("midrst_empty", 32'(rx_empty), 32'd1);
    exp_q.push_back(11'h096);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
    read_head("post_reset");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
